// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state type, width helper and sim prescaler constant for key conditioning
package key_pkg;

  localparam int SIM_TICK_DIV = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one button channel: synchronizer, tick-based debounce, hold/long/repeat FSM
module key_channel
  import key_pkg::*;
#(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic resetIn,
  input  logic tick,
  input  logic key_raw,
  input  logic repeat_en,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int   DB_W     = cnt_width(DEBOUNCE_MS);
  localparam int   HOLD_W   = cnt_width(LONG_MS);
  localparam int   REP_W    = cnt_width(REPEAT_MS);
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic              sync1, sync2, pressed, differ;
  logic [DB_W-1:0]   db_cnt, db_cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_n;
  key_state_e        state, state_n;
  logic              level_n, press_n, release_n, long_n, repeat_n;

  assign pressed = ACTIVE_LOW ? ~sync2 : sync2;
  assign differ  = (pressed != key_level);

  always_comb begin
    state_n    = state;
    level_n    = key_level;
    db_cnt_n   = db_cnt;
    hold_cnt_n = hold_cnt;
    rep_cnt_n  = rep_cnt;
    press_n    = 1'b0;
    release_n  = 1'b0;
    long_n     = 1'b0;
    repeat_n   = 1'b0;

    if (tick) begin
      if (!differ) begin
        db_cnt_n = '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
        db_cnt_n  = '0;
        level_n   = pressed;
        press_n   = pressed;
        release_n = ~pressed;
      end else begin
        db_cnt_n = db_cnt + 1'b1;
      end
    end

    // An accepted release wins over any long/repeat event on the same tick.
    case (state)
      IDLE: begin
        if (press_n) begin
          state_n    = HELD;
          hold_cnt_n = '0;
        end
      end
      HELD: begin
        if (release_n) begin
          state_n = IDLE;
        end else if (tick) begin
          if (hold_cnt == HOLD_W'(LONG_MS - 1)) begin
            long_n    = 1'b1;
            state_n   = LONG;
            rep_cnt_n = '0;
          end
          if (hold_cnt != HOLD_W'(LONG_MS)) hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (release_n) begin
          state_n = IDLE;
        end else if (!repeat_en) begin
          rep_cnt_n = '0;
        end else if (tick) begin
          if (rep_cnt == REP_W'(REPEAT_MS - 1)) begin
            repeat_n  = 1'b1;
            rep_cnt_n = '0;
          end else begin
            rep_cnt_n = rep_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetIn) begin
      sync1       <= IDLE_LVL;
      sync2       <= IDLE_LVL;
      state       <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      state       <= state_n;
      db_cnt      <= db_cnt_n;
      hold_cnt    <= hold_cnt_n;
      rep_cnt     <= rep_cnt_n;
      key_level   <= level_n;
      key_press   <= press_n;
      key_release <= release_n;
      key_long    <= long_n;
      key_repeat  <= repeat_n;
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - shared 1 ms prescaler driving N independent key channels
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int TICK_DIV    = 6000,
  parameter bit SIM         = 1'b0,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic [N_KEYS-1:0] keys_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic              tick_1k,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int DIV   = SIM ? SIM_TICK_DIV : TICK_DIV;
  localparam int PRE_W = cnt_width(DIV - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick_1k = (pre_cnt == PRE_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetIn)     pre_cnt <= '0;
    else if (tick_1k) pre_cnt <= '0;
    else              pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_ch (
      .clk        (clk),
      .resetIn    (resetIn),
      .tick       (tick_1k),
      .key_raw    (keys_in[i]),
      .repeat_en  (repeat_en[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - directed self-checking bench for key_debounce_multi
module tb_key_debounce_multi;

  localparam int CPM = 10;

  logic       clk = 1'b0;
  logic       resetIn;
  logic [3:0] keys_in, repeat_en;
  logic       tick_1k, s_tick;
  logic [3:0] key_level, key_press, key_release, key_long, key_repeat;
  logic [3:0] s_level, s_press, s_release, s_long, s_repeat;

  int n_vec = 0, n_err = 0;
  int unsigned cyc = 0;
  int n_press[4], n_release[4], n_long[4], n_repeat[4];
  int press_c[4], release_c[4], long_c[4];
  int rep_hist[4][8];
  int b_press[4], b_release[4], b_long[4], b_repeat[4];

  key_debounce_multi #(
    .N_KEYS(4), .TICK_DIV(CPM), .SIM(1'b0), .ACTIVE_LOW(1'b1),
    .DEBOUNCE_MS(20), .LONG_MS(1000), .REPEAT_MS(200)
  ) dut (
    .clk(clk), .resetIn(resetIn), .keys_in(keys_in), .repeat_en(repeat_en),
    .tick_1k(tick_1k), .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long), .key_repeat(key_repeat)
  );

  key_debounce_multi #(.N_KEYS(4), .TICK_DIV(CPM), .SIM(1'b1)) dut_sim (
    .clk(clk), .resetIn(resetIn), .keys_in(keys_in), .repeat_en(repeat_en),
    .tick_1k(s_tick), .key_level(s_level), .key_press(s_press),
    .key_release(s_release), .key_long(s_long), .key_repeat(s_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[2'(i)]) begin
        n_press[2'(i)] <= n_press[2'(i)] + 1;
        press_c[2'(i)] <= cyc;
      end
      if (key_release[2'(i)]) begin
        n_release[2'(i)] <= n_release[2'(i)] + 1;
        release_c[2'(i)] <= cyc;
      end
      if (key_long[2'(i)]) begin
        n_long[2'(i)] <= n_long[2'(i)] + 1;
        long_c[2'(i)] <= cyc;
      end
      if (key_repeat[2'(i)]) begin
        n_repeat[2'(i)] <= n_repeat[2'(i)] + 1;
        rep_hist[2'(i)][3'(n_repeat[2'(i)])] <= cyc;
      end
    end
  end

  task automatic wait_ms(input int ms);
    repeat (ms * CPM) @(negedge clk);
  endtask

  task automatic snap();
    b_press = n_press; b_release = n_release; b_long = n_long; b_repeat = n_repeat;
  endtask

  task automatic align_tick();
    int t = 0;
    while (!tick_1k && t < 2 * CPM) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (tick_1k !== 1'b1) begin
      n_err++;
      $display("FAIL align_tick: tick_1k=%b after %0d clks, want 1", tick_1k, t);
    end
  endtask

  task automatic test_reset();
    int t_fast = 0, t_sim = 0, n_ticks = 0;
    resetIn = 1'b0; keys_in = 4'hF; repeat_en = 4'h0;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({tick_1k, key_level, key_press, key_release, key_long, key_repeat} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {tick_1k, key_level, key_press, key_release, key_long, key_repeat});
    end
    n_vec++;
    if ({s_tick, s_level, s_press, s_release, s_long, s_repeat} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs_sim: got %h want 0",
               {s_tick, s_level, s_press, s_release, s_long, s_repeat});
    end
    resetIn = 1'b1;
    for (int n = 1; n <= 1005; n++) begin
      if (tick_1k === 1'b1) begin
        n_ticks++;
        if (t_fast == 0) t_fast = n;
      end
      if (s_tick === 1'b1 && t_sim == 0) t_sim = n;
      @(negedge clk);
    end
    n_vec++;
    if (t_sim != 1000) begin
      n_err++;
      $display("FAIL first_tick_sim: got clk %0d want 1000", t_sim);
    end
    n_vec++;
    if (t_fast != CPM) begin
      n_err++;
      $display("FAIL first_tick_div: got clk %0d want %0d", t_fast, CPM);
    end
    n_vec++;
    if (n_ticks != 100) begin
      n_err++;
      $display("FAIL tick_count: got %0d want 100", n_ticks);
    end
  endtask

  task automatic test_bounce();
    int others, dur;
    snap();
    align_tick();
    for (int s = 0; s < 100; s++) begin
      keys_in[0] = (s < 10 || s >= 90) ? s[0] : 1'b0;
      repeat (5) @(negedge clk);
    end
    keys_in[0] = 1'b1;
    wait_ms(30);
    n_vec++;
    if (n_press[0] - b_press[0] != 1 || n_release[0] - b_release[0] != 1) begin
      n_err++;
      $display("FAIL bounce_strobes: press %0d release %0d want 1 1",
               n_press[0] - b_press[0], n_release[0] - b_release[0]);
    end
    dur = release_c[0] - press_c[0];
    n_vec++;
    if (dur < 34 * CPM || dur > 46 * CPM) begin
      n_err++;
      $display("FAIL bounce_level_width: got %0d clks want %0d..%0d", dur, 34 * CPM, 46 * CPM);
    end
    n_vec++;
    if (n_long[0] != b_long[0] || key_level[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_no_long: long %0d level %b want 0 0", n_long[0] - b_long[0], key_level[0]);
    end
    others = 0;
    for (int c = 1; c < 4; c++)
      others += n_press[2'(c)] - b_press[2'(c)] + n_release[2'(c)] - b_release[2'(c)]
              + n_long[2'(c)] - b_long[2'(c)] + n_repeat[2'(c)] - b_repeat[2'(c)];
    n_vec++;
    if (others != 0) begin
      n_err++;
      $display("FAIL bounce_other_quiet: got %0d strobes want 0", others);
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    snap();
    keys_in[1] = 1'b0;
    repeat (15 * CPM) begin
      @(negedge clk);
      seen |= key_level[1];
    end
    keys_in[1] = 1'b1;
    repeat (25 * CPM) begin
      @(negedge clk);
      seen |= key_level[1];
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_level: got %b want 0", seen);
    end
    n_vec++;
    if (n_press[1] != b_press[1] || n_release[1] != b_release[1]) begin
      n_err++;
      $display("FAIL glitch_strobes: press %0d release %0d want 0 0",
               n_press[1] - b_press[1], n_release[1] - b_release[1]);
    end
  endtask

  task automatic test_long_repeat(input bit rep);
    int r_cyc, d_rel;
    snap();
    repeat_en[2] = rep;
    keys_in[2] = 1'b0;
    wait_ms(1500);
    r_cyc = cyc;
    keys_in[2] = 1'b1;
    wait_ms(30);
    repeat_en[2] = 1'b0;
    n_vec++;
    if (n_press[2] - b_press[2] != 1 || n_long[2] - b_long[2] != 1) begin
      n_err++;
      $display("FAIL long%0d_counts: press %0d long %0d want 1 1", rep,
               n_press[2] - b_press[2], n_long[2] - b_long[2]);
    end
    n_vec++;
    if (long_c[2] - press_c[2] != 1000 * CPM) begin
      n_err++;
      $display("FAIL long%0d_delay: got %0d clks want %0d", rep, long_c[2] - press_c[2], 1000 * CPM);
    end
    n_vec++;
    if (n_repeat[2] - b_repeat[2] != (rep ? 2 : 0)) begin
      n_err++;
      $display("FAIL long%0d_repeat_count: got %0d want %0d", rep,
               n_repeat[2] - b_repeat[2], rep ? 2 : 0);
    end
    if (rep) begin
      n_vec++;
      if (rep_hist[2][3'(b_repeat[2])] - long_c[2] != 200 * CPM ||
          rep_hist[2][3'(b_repeat[2] + 1)] - long_c[2] != 400 * CPM) begin
        n_err++;
        $display("FAIL long_repeat_times: got +%0d +%0d want +%0d +%0d",
                 rep_hist[2][3'(b_repeat[2])] - long_c[2],
                 rep_hist[2][3'(b_repeat[2] + 1)] - long_c[2], 200 * CPM, 400 * CPM);
      end
    end
    d_rel = release_c[2] - r_cyc;
    n_vec++;
    if (n_release[2] - b_release[2] != 1 || d_rel < 19 * CPM || d_rel > 21 * CPM) begin
      n_err++;
      $display("FAIL long%0d_release: count %0d delay %0d want 1 %0d..%0d", rep,
               n_release[2] - b_release[2], d_rel, 19 * CPM, 21 * CPM);
    end
  endtask

  task automatic test_simultaneous();
    keys_in[3] = 1'b0;
    wait_ms(25);
    n_vec++;
    if (key_level !== 4'b1000) begin
      n_err++;
      $display("FAIL simul_setup: key_level %b want 1000", key_level);
    end
    snap();
    align_tick();
    keys_in[0] = 1'b0;
    keys_in[3] = 1'b1;
    wait_ms(25);
    n_vec++;
    if (n_press[0] - b_press[0] != 1 || n_release[3] - b_release[3] != 1) begin
      n_err++;
      $display("FAIL simul_counts: press0 %0d release3 %0d want 1 1",
               n_press[0] - b_press[0], n_release[3] - b_release[3]);
    end
    n_vec++;
    if (press_c[0] != release_c[3]) begin
      n_err++;
      $display("FAIL simul_same_clk: press0 at %0d release3 at %0d want equal", press_c[0], release_c[3]);
    end
    n_vec++;
    if (key_level !== 4'b0001 || n_release[0] != b_release[0] || n_press[3] != b_press[3]) begin
      n_err++;
      $display("FAIL simul_cross: level %b release0 %0d press3 %0d want 0001 0 0",
               key_level, n_release[0] - b_release[0], n_press[3] - b_press[3]);
    end
    keys_in[0] = 1'b1;
    wait_ms(25);
  endtask

  task automatic test_reset_in_long();
    int t = 0, r_cyc;
    snap();
    keys_in[2] = 1'b0;
    while (n_long[2] == b_long[2] && t < 12000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (n_long[2] - b_long[2] != 1) begin
      n_err++;
      $display("FAIL rst_long_reached: long %0d after %0d clks want 1", n_long[2] - b_long[2], t);
    end
    resetIn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({key_level, key_press, key_release, key_long, key_repeat, tick_1k} !== 21'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {key_level, key_press, key_release, key_long, key_repeat, tick_1k});
    end
    snap();
    resetIn = 1'b1;
    r_cyc = cyc;
    wait_ms(25);
    n_vec++;
    if (n_release[2] != b_release[2]) begin
      n_err++;
      $display("FAIL rst_no_release: got %0d want 0", n_release[2] - b_release[2]);
    end
    n_vec++;
    if (n_press[2] - b_press[2] != 1 || press_c[2] - r_cyc != 20 * CPM) begin
      n_err++;
      $display("FAIL rst_repress: count %0d delay %0d want 1 %0d",
               n_press[2] - b_press[2], press_c[2] - r_cyc, 20 * CPM);
    end
    keys_in[2] = 1'b1;
    wait_ms(25);
    n_vec++;
    if (n_release[2] - b_release[2] != 1 || key_level !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_final_release: count %0d level %b want 1 0000",
               n_release[2] - b_release[2], key_level);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_glitch();
    test_long_repeat(1'b1);
    test_long_repeat(1'b0);
    test_simultaneous();
    test_reset_in_long();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
